// File: rtl/manchester_rx_ctrl.sv
// Manchester receive controller: measures edge-to-edge intervals, hunts for a
// preamble of long intervals, then decodes mid-bit edges into bits.
module manchester_rx_ctrl #(
  parameter int HALF_PERIOD = 8,
  parameter int TOL         = 2,
  parameter int SYNC_LONGS  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic edge_re_i,
  input  logic edge_fe_i,
  output logic bit_out_o,
  output logic bit_valid_o,
  output logic locked_o,
  output logic frame_end_o,
  output logic err_o
);

  localparam int CNT_MAX = 2 * HALF_PERIOD + TOL + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int LCW     = $clog2(SYNC_LONGS + 1);

  localparam logic [CW-1:0] SHORT_MIN = CW'(HALF_PERIOD - TOL);
  localparam logic [CW-1:0] SHORT_MAX = CW'(HALF_PERIOD + TOL);
  localparam logic [CW-1:0] LONG_MIN  = CW'(2 * HALF_PERIOD - TOL);
  localparam logic [CW-1:0] LONG_MAX  = CW'(2 * HALF_PERIOD + TOL);
  localparam logic [CW-1:0] SAT_VAL   = CW'(CNT_MAX);
  localparam logic [LCW-1:0] LAST_LONG = LCW'(SYNC_LONGS - 1);

  typedef enum logic {HUNT, DATA} state_e;
  typedef enum logic {MID, BOUND} phase_e;

  state_e         state_q, state_d;
  phase_e         phase_q, phase_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LCW-1:0] long_cnt_q, long_cnt_d;
  logic           have_ref_q, have_ref_d;
  logic           bit_q, bit_d;
  logic           bit_valid_q, bit_valid_d;
  logic           err_q, err_d;
  logic           frame_end_q, frame_end_d;

  logic edge_ev, glitch, timeout, is_short, is_long;

  assign edge_ev  = edge_re_i ^ edge_fe_i;
  assign glitch   = edge_re_i & edge_fe_i;
  assign timeout  = have_ref_q && (cnt_q == SAT_VAL);
  assign is_short = (cnt_q >= SHORT_MIN) && (cnt_q <= SHORT_MAX);
  assign is_long  = (cnt_q >= LONG_MIN) && (cnt_q <= LONG_MAX);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    have_ref_d  = have_ref_q;
    long_cnt_d  = long_cnt_q;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    err_d       = 1'b0;
    frame_end_d = 1'b0;

    if (edge_ev) begin
      cnt_d = CW'(1);
    end else if (cnt_q != SAT_VAL) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Glitch outranks an edge, and a real edge outranks a coincident timeout.
    case (state_q)
      HUNT: begin
        if (glitch) begin
          long_cnt_d = '0;
          have_ref_d = 1'b0;
        end else if (edge_ev) begin
          have_ref_d = 1'b1;
          if (have_ref_q) begin
            if (!is_long) begin
              long_cnt_d = '0;
            end else if (long_cnt_q == LAST_LONG) begin
              state_d    = DATA;
              phase_d    = MID;
              long_cnt_d = '0;
            end else begin
              long_cnt_d = long_cnt_q + LCW'(1);
            end
          end
        end else if (timeout) begin
          long_cnt_d = '0;
          have_ref_d = 1'b0;
        end
      end

      DATA: begin
        if (glitch) begin
          err_d      = 1'b1;
          state_d    = HUNT;
          have_ref_d = 1'b0;
          long_cnt_d = '0;
        end else if (edge_ev) begin
          have_ref_d = 1'b1;
          if (is_long && phase_q == MID) begin
            bit_valid_d = 1'b1;
            bit_d       = edge_re_i;
          end else if (is_short && phase_q == MID) begin
            phase_d = BOUND;
          end else if (is_short && phase_q == BOUND) begin
            bit_valid_d = 1'b1;
            bit_d       = edge_re_i;
            phase_d     = MID;
          end else begin
            err_d      = 1'b1;
            state_d    = HUNT;
            long_cnt_d = '0;
          end
        end else if (timeout) begin
          frame_end_d = 1'b1;
          state_d     = HUNT;
          have_ref_d  = 1'b0;
          long_cnt_d  = '0;
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      phase_q     <= MID;
      cnt_q       <= '0;
      long_cnt_q  <= '0;
      have_ref_q  <= 1'b0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      err_q       <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      long_cnt_q  <= long_cnt_d;
      have_ref_q  <= have_ref_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      err_q       <= err_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign bit_out_o   = bit_q;
  assign bit_valid_o = bit_valid_q;
  assign locked_o    = (state_q == DATA);
  assign frame_end_o = frame_end_q;
  assign err_o       = err_q;

endmodule
